// File: rtl/bus_xing_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_xing_pkg
// Brief    : Shared constants for the toggle-handshake bus crossing and its
//            receive-side packer.
// Revision : 1.0
// ============================================================================
package bus_xing_pkg;

    localparam int BUS_DATA_W = 8;
    localparam int BUS_LANES  = 4;
    localparam int BUS_DEPTH  = 4;

    localparam int LANE_IDX_W = $clog2(BUS_LANES);
    localparam int LEVEL_W    = $clog2(BUS_DEPTH + 1);

endpackage
`default_nettype wire

// File: rtl/bus_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_sync_fifo
// Brief    : Single-clock register-array FIFO with an occupancy counter.
// Revision : 1.0
// ============================================================================
module bus_sync_fifo
    import bus_xing_pkg::*;
#(
    parameter int WIDTH = BUS_DATA_W * BUS_LANES,
    parameter int DEPTH = BUS_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [LVL_W-1:0] o_level,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_level == LVL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign w_do_pop  = i_pop & ~o_empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    // Empty FIFO presents zero so the unreset storage never leaks out.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_level <= r_level + LVL_W'(1);
            else if (!w_do_push && w_do_pop) r_level <= r_level - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule
`default_nettype wire

// File: rtl/bus_rx_packer.sv
`default_nettype none
// ============================================================================
// Module   : bus_rx_packer
// Brief    : Packs LANES crossing words little-endian into wide words and
//            buffers them in a FIFO exposed as a valid/ready stream.
// Revision : 1.0
// ============================================================================
module bus_rx_packer
    import bus_xing_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int LANES  = BUS_LANES,
    parameter int DEPTH  = BUS_DEPTH,
    localparam int LANE_W = $clog2(LANES),
    localparam int LVL_W  = $clog2(DEPTH + 1),
    localparam int OUT_W  = DATA_W * LANES,
    localparam int PART_W = DATA_W * (LANES - 1)
) (
    input  logic              clkB,
    input  logic              rstB_n,
    input  logic              FlagIn_clkB,
    input  logic [DATA_W-1:0] BusIn,
    input  logic              Flush,
    input  logic              OutReady,
    output logic              OutValid,
    output logic [OUT_W-1:0]  OutData,
    output logic [LVL_W-1:0]  Level,
    output logic [LANE_W-1:0] LanePos,
    output logic              Overflow,
    input  logic              ClearOvf
);

    logic [PART_W-1:0] r_part;
    logic [LANE_W-1:0] r_lane;
    logic              r_ovf;
    logic              w_accept;
    logic              w_last;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic              w_drop;
    logic [OUT_W-1:0]  w_word;

    assign w_accept = FlagIn_clkB & ~Flush;
    assign w_last   = w_accept & (r_lane == LANE_W'(LANES - 1));
    assign w_pop    = ~w_empty & OutReady;
    assign w_drop   = w_last & w_full & ~w_pop;
    assign w_word   = {BusIn, r_part};

    assign OutValid = ~w_empty;
    assign LanePos  = r_lane;
    assign Overflow = r_ovf;

    always_ff @(posedge clkB or negedge rstB_n) begin
        if (!rstB_n) begin
            r_part <= '0;
            r_lane <= '0;
            r_ovf  <= 1'b0;
        end else begin
            // Lanes are never cleared after a push; each is rewritten before reuse.
            for (int i = 0; i < LANES - 1; i++) begin
                if (w_accept && r_lane == LANE_W'(i))
                    r_part[i*DATA_W +: DATA_W] <= BusIn;
            end
            if (Flush)         r_lane <= '0;
            else if (w_accept) r_lane <= r_lane + LANE_W'(1);
            if (w_drop)        r_ovf <= 1'b1;
            else if (ClearOvf) r_ovf <= 1'b0;
        end
    end

    bus_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clkB),
        .rst_n   (rstB_n),
        .i_push  (w_last),
        .i_data  (w_word),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (Level),
        .o_data  (OutData)
    );

endmodule
`default_nettype wire

// File: tb/tb_bus_rx_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_rx_packer
// Brief    : Directed vector bench for bus_rx_packer (default parameters).
// Revision : 1.0
// ============================================================================
module tb_bus_rx_packer;

    typedef struct {
        logic        flag;
        logic [7:0]  bus;
        logic        flush;
        logic        ready;
        logic        clr;
        logic        ev;
        logic [31:0] ed;
        logic [2:0]  el;
        logic [1:0]  elane;
        logic        eovf;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flag;
    logic [7:0]  bus;
    logic        flush;
    logic        ready;
    logic        clr;
    logic        o_valid;
    logic [31:0] o_data;
    logic [2:0]  o_level;
    logic [1:0]  o_lane;
    logic        o_ovf;

    int   checks;
    int   errors;
    vec_t vecs[$];

    bus_rx_packer dut (
        .clkB        (clk),
        .rstB_n      (rst_n),
        .FlagIn_clkB (flag),
        .BusIn       (bus),
        .Flush       (flush),
        .OutReady    (ready),
        .OutValid    (o_valid),
        .OutData     (o_data),
        .Level       (o_level),
        .LanePos     (o_lane),
        .Overflow    (o_ovf),
        .ClearOvf    (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic add(input logic f, input logic [7:0] b, input logic fl, input logic rd,
                       input logic cl, input logic ev, input logic [31:0] ed,
                       input logic [2:0] el, input logic [1:0] ln, input logic eo);
        vec_t v;
        v.flag = f; v.bus = b; v.flush = fl; v.ready = rd; v.clr = cl;
        v.ev = ev; v.ed = ed; v.el = el; v.elane = ln; v.eovf = eo;
        vecs.push_back(v);
    endtask

    // 16 strobes into an empty FIFO with no consumer; head is the first group.
    task automatic add_fill(input logic [7:0] base);
        logic [31:0] head;
        head = {base + 8'd3, base + 8'd2, base + 8'd1, base};
        for (int k = 0; k < 16; k++)
            add(1, base + 8'(k), 0, 0, 0, (k >= 3), head, 3'((k + 1) / 4), 2'((k + 1) % 4), 0);
    endtask

    task automatic apply(input vec_t v, input int idx);
        string tag;
        flag = v.flag; bus = v.bus; flush = v.flush; ready = v.ready; clr = v.clr;
        @(posedge clk);
        #1;
        tag = $sformatf("v%0d", idx);
        chk({tag, ".valid"}, 32'(o_valid), 32'(v.ev));
        chk({tag, ".level"}, 32'(o_level), 32'(v.el));
        chk({tag, ".lane"},  32'(o_lane),  32'(v.elane));
        chk({tag, ".ovf"},   32'(o_ovf),   32'(v.eovf));
        if (v.ev) chk({tag, ".data"}, o_data, v.ed);
    endtask

    task automatic strobe(input logic [7:0] b, input logic rd);
        flag = 1; bus = b; flush = 0; ready = rd; clr = 0;
        @(posedge clk);
        #1;
        flag = 0;
    endtask

    initial begin
        checks = 0; errors = 0;
        flag = 0; bus = '0; flush = 0; ready = 0; clr = 0;
        rst_n = 0;

        // Basic 4-lane pack, latency 1, immediate pop
        add(1, 8'h11, 0, 1, 0, 0, 0, 0, 1, 0);
        add(1, 8'h22, 0, 1, 0, 0, 0, 0, 2, 0);
        add(1, 8'h33, 0, 1, 0, 0, 0, 0, 3, 0);
        add(1, 8'h44, 0, 1, 0, 1, 32'h44332211, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        // Fill to full, then one dropped group
        add_fill(8'h00);
        add(1, 8'h10, 0, 0, 0, 1, 32'h03020100, 4, 1, 0);
        add(1, 8'h11, 0, 0, 0, 1, 32'h03020100, 4, 2, 0);
        add(1, 8'h12, 0, 0, 0, 1, 32'h03020100, 4, 3, 0);
        add(1, 8'h13, 0, 0, 0, 1, 32'h03020100, 4, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1, 32'h07060504, 3, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1, 32'h0B0A0908, 2, 0, 1);
        add(0, 8'h00, 0, 1, 0, 1, 32'h0F0E0D0C, 1, 0, 1);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1);
        add(0, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0);
        // Full FIFO, last-lane strobe with simultaneous pop
        add_fill(8'h20);
        add(1, 8'h30, 0, 0, 0, 1, 32'h23222120, 4, 1, 0);
        add(1, 8'h31, 0, 0, 0, 1, 32'h23222120, 4, 2, 0);
        add(1, 8'h32, 0, 0, 0, 1, 32'h23222120, 4, 3, 0);
        add(1, 8'h33, 0, 1, 0, 1, 32'h27262524, 4, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 32'h2B2A2928, 3, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 32'h2F2E2D2C, 2, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 32'h33323130, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        // Flush discards a partial group
        add(1, 8'hAA, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'hBB, 0, 0, 0, 0, 0, 0, 2, 0);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 8'h01, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h02, 0, 0, 0, 0, 0, 0, 2, 0);
        add(1, 8'h03, 0, 0, 0, 0, 0, 0, 3, 0);
        add(1, 8'h04, 0, 0, 0, 1, 32'h04030201, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);
        // Flush beats a coincident last-lane strobe
        add(1, 8'h05, 0, 0, 0, 0, 0, 0, 1, 0);
        add(1, 8'h06, 0, 0, 0, 0, 0, 0, 2, 0);
        add(1, 8'h07, 0, 0, 0, 0, 0, 0, 3, 0);
        add(1, 8'h08, 1, 0, 0, 0, 0, 0, 0, 0);
        add(0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        // Drop with ClearOvf in the same cycle: set wins; then clear alone
        add_fill(8'h40);
        add(1, 8'h50, 0, 0, 0, 1, 32'h43424140, 4, 1, 0);
        add(1, 8'h51, 0, 0, 0, 1, 32'h43424140, 4, 2, 0);
        add(1, 8'h52, 0, 0, 0, 1, 32'h43424140, 4, 3, 0);
        add(1, 8'h53, 0, 0, 1, 1, 32'h43424140, 4, 0, 1);
        add(0, 8'h00, 0, 0, 1, 1, 32'h43424140, 4, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 32'h47464544, 3, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 32'h4B4A4948, 2, 0, 0);
        add(0, 8'h00, 0, 1, 0, 1, 32'h4F4E4D4C, 1, 0, 0);
        add(0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);

        // Reset state
        #12;
        chk("rst.valid", 32'(o_valid), 0);
        chk("rst.level", 32'(o_level), 0);
        chk("rst.lane",  32'(o_lane),  0);
        chk("rst.ovf",   32'(o_ovf),   0);
        chk("rst.data",  o_data,       0);
        @(posedge clk);
        #1;
        rst_n = 1;

        foreach (vecs[i]) apply(vecs[i], i);
        flag = 0; flush = 0; ready = 0; clr = 0;

        // Asynchronous reset mid-group with a non-empty FIFO
        strobe(8'h61, 0); strobe(8'h62, 0); strobe(8'h63, 0); strobe(8'h64, 0);
        strobe(8'h65, 0); strobe(8'h66, 0);
        chk("pre.level", 32'(o_level), 1);
        chk("pre.lane",  32'(o_lane),  2);
        #3;
        rst_n = 0;
        #1;
        chk("arst.valid", 32'(o_valid), 0);
        chk("arst.level", 32'(o_level), 0);
        chk("arst.lane",  32'(o_lane),  0);
        flag = 1; bus = 8'hEE;
        @(posedge clk);
        #1;
        chk("arst.hold_lane", 32'(o_lane), 0);
        flag = 0;
        rst_n = 1;
        strobe(8'h01, 0); strobe(8'h02, 0); strobe(8'h03, 0);
        chk("post.lane", 32'(o_lane), 3);
        strobe(8'h04, 0);
        chk("post.valid", 32'(o_valid), 1);
        chk("post.data",  o_data, 32'h04030201);
        chk("post.level", 32'(o_level), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
